ascon_sbox_layer_seq: RTL and testbench
=======================================

Name: ascon_sbox_layer_seq

Overview:
Sequential, parametrised Ascon substitution layer. It applies the 5-bit Ascon S-box, or optionally its inverse, to all 64 columns of the 320-bit permutation state. It processes PAR columns per clock and uses a start/done handshake. It sits between the constant-addition and linear-diffusion stages of the permutation datapath and lets area and throughput be traded through PAR.

Parameters:
PAR, 8, columns substituted per clock; legal values 1, 2, 4, 8, 16, 32, 64 (elaboration error otherwise)
NB (derived, not overridable), 64/PAR, number of processing cycles per layer

Ports:
clock_i  input  1  system clock, rising edge
resetb_i  input  1  asynchronous active-low reset
start_i  input  1  request; sampled only while idle
inv_i  input  1  0 = forward S-box, 1 = inverse S-box; sampled with start_i
state_i  input  320  packed {x0,x1,x2,x3,x4}, x0 at [319:256], x4 at [63:0]
state_o  output  320  working state register, same packing
busy_o  output  1  high while a layer is in progress
done_o  output  1  one-cycle pulse when state_o holds the completed result

Behaviour:
- Column j (0..63) is the 5-bit value {x0[j],x1[j],x2[j],x3[j],x4[j]}, with x0 as the MSB. The result is written back to the same bit positions.
- Forward table, inputs 0x00..0x1F: 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17.
- Inverse table: the exact inverse permutation of the forward table, e.g. inv(0x04)=0x00, inv(0x00)=0x14, inv(0x17)=0x1F.
- The PAR S-box instances are purely combinational. The mode is selected per layer from the latched inv_i.
- Reset (asynchronous, resetb_i low):
  - FSM goes to IDLE.
  - Column counter = 0.
  - State register = 0, so state_o = 0.
  - busy_o = 0, done_o = 0.
  - Latched mode = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1 at the edge: load state_i into the state register, latch inv_i, counter=0, go to RUN.
  - Otherwise hold. State register is unchanged.
- RUN:
  - Each edge substitutes columns [cnt*PAR, cnt*PAR+PAR-1] in place, then cnt increments.
  - On the edge where cnt = NB-1: cnt wraps to 0 and the FSM goes to DONE.
- DONE: lasts exactly one cycle, with done_o=1. The next edge returns to IDLE.
- busy_o = 1 in RUN and DONE, 0 in IDLE.
- Latency: if start is sampled at edge E, done_o is high during the cycle after edge E+NB. Minimum start-to-start spacing is NB+2 cycles.
  - PAR=64: done in the cycle after E+1.
  - PAR=8: done in the cycle after E+8.
- start_i while busy_o=1 (including during DONE) is ignored. state_i and inv_i changes while busy have no effect.
- state_o is the live register. Partially substituted values are visible during RUN and are not valid until done_o. The result holds in IDLE until the next accepted start.
- Columns not in the current batch are never modified. Each column is substituted exactly once per layer.
- Reset asserted mid-operation aborts immediately; no done_o pulse. After release the block is in IDLE and accepts a new start on the first edge.
- Counter width is max(1, log2(NB)) bits. For PAR=64 the block goes RUN→DONE after one edge.

Test Plan:
- PAR=8, forward, state_i=0 → done_o after 8 RUN edges; state_o: x2=FFFF_FFFF_FFFF_FFFF, x0=x1=x3=x4=0; busy_o high for 9 cycles.
- PAR=64, forward, state_i all ones → done_o in the cycle after the second edge; x0=x2=x3=x4=all ones, x1=0.
- PAR=8, inverse, state_i=0 → x0=x2=all ones, x1=x3=x4=0. Then feed that back with inv_i=0 → state_o=0 (round trip).
- Any PAR, random states (≥200), forward then inverse, compared against a 32-entry table model → bit-exact; all 32 column values exercised at every column position.
- start_i held high through a whole layer with changing state_i/inv_i → only one layer executes and inputs after acceptance are ignored; a new start is accepted in the first IDLE cycle.
- resetb_i pulsed low at RUN cnt=3 (PAR=8) → state_o=0, busy_o=0, no done_o; a subsequent start completes normally with correct result.

Source files
------------

// File: rtl/ascon_sbox_layer_seq.sv
// Sequential Ascon substitution layer: forward or inverse 5-bit S-box over all 64 columns,
// PAR columns per clock, start/busy/done handshake.
module ascon_sbox_layer_seq #(
    parameter int PAR = 8
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic         inv_i,
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int NB = 64 / PAR;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    if (!(PAR == 1 || PAR == 2 || PAR == 4 || PAR == 8 ||
          PAR == 16 || PAR == 32 || PAR == 64)) begin : g_parCheck
        $error("ascon_sbox_layer_seq: PAR must be one of 1, 2, 4, 8, 16, 32, 64");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_e;

    fsm_e           r_fsm;
    fsm_e           w_fsmNext;
    logic [319:0]   r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_inv;

    logic [63:0]    w_x      [5];
    logic [63:0]    w_xSub   [5];
    logic [319:0]   w_stateSub;
    logic [5:0]     w_base;
    logic           w_lastBatch;
    logic [5:0]     w_colIdx [PAR];
    logic [4:0]     w_sboxIn [PAR];
    logic [4:0]     w_sboxOut[PAR];

    function automatic logic [4:0] sboxFwd(input logic [4:0] a);
        sboxFwd = 5'h00;
        case (a)
            5'h00: sboxFwd = 5'h04;
            5'h01: sboxFwd = 5'h0B;
            5'h02: sboxFwd = 5'h1F;
            5'h03: sboxFwd = 5'h14;
            5'h04: sboxFwd = 5'h1A;
            5'h05: sboxFwd = 5'h15;
            5'h06: sboxFwd = 5'h09;
            5'h07: sboxFwd = 5'h02;
            5'h08: sboxFwd = 5'h1B;
            5'h09: sboxFwd = 5'h05;
            5'h0A: sboxFwd = 5'h08;
            5'h0B: sboxFwd = 5'h12;
            5'h0C: sboxFwd = 5'h1D;
            5'h0D: sboxFwd = 5'h03;
            5'h0E: sboxFwd = 5'h06;
            5'h0F: sboxFwd = 5'h1C;
            5'h10: sboxFwd = 5'h1E;
            5'h11: sboxFwd = 5'h13;
            5'h12: sboxFwd = 5'h07;
            5'h13: sboxFwd = 5'h0E;
            5'h14: sboxFwd = 5'h00;
            5'h15: sboxFwd = 5'h0D;
            5'h16: sboxFwd = 5'h11;
            5'h17: sboxFwd = 5'h18;
            5'h18: sboxFwd = 5'h10;
            5'h19: sboxFwd = 5'h0C;
            5'h1A: sboxFwd = 5'h01;
            5'h1B: sboxFwd = 5'h19;
            5'h1C: sboxFwd = 5'h16;
            5'h1D: sboxFwd = 5'h0A;
            5'h1E: sboxFwd = 5'h0F;
            5'h1F: sboxFwd = 5'h17;
            default: sboxFwd = 5'h00;
        endcase
    endfunction

    // Exact inverse permutation of sboxFwd
    function automatic logic [4:0] sboxInv(input logic [4:0] a);
        sboxInv = 5'h00;
        case (a)
            5'h00: sboxInv = 5'h14;
            5'h01: sboxInv = 5'h1A;
            5'h02: sboxInv = 5'h07;
            5'h03: sboxInv = 5'h0D;
            5'h04: sboxInv = 5'h00;
            5'h05: sboxInv = 5'h09;
            5'h06: sboxInv = 5'h0E;
            5'h07: sboxInv = 5'h12;
            5'h08: sboxInv = 5'h0A;
            5'h09: sboxInv = 5'h06;
            5'h0A: sboxInv = 5'h1D;
            5'h0B: sboxInv = 5'h01;
            5'h0C: sboxInv = 5'h19;
            5'h0D: sboxInv = 5'h15;
            5'h0E: sboxInv = 5'h13;
            5'h0F: sboxInv = 5'h1E;
            5'h10: sboxInv = 5'h18;
            5'h11: sboxInv = 5'h16;
            5'h12: sboxInv = 5'h0B;
            5'h13: sboxInv = 5'h11;
            5'h14: sboxInv = 5'h03;
            5'h15: sboxInv = 5'h05;
            5'h16: sboxInv = 5'h1C;
            5'h17: sboxInv = 5'h1F;
            5'h18: sboxInv = 5'h17;
            5'h19: sboxInv = 5'h1B;
            5'h1A: sboxInv = 5'h04;
            5'h1B: sboxInv = 5'h08;
            5'h1C: sboxInv = 5'h0F;
            5'h1D: sboxInv = 5'h0C;
            5'h1E: sboxInv = 5'h10;
            5'h1F: sboxInv = 5'h02;
            default: sboxInv = 5'h00;
        endcase
    endfunction

    for (genvar i = 0; i < 5; i++) begin : g_words
        assign w_x[i] = r_state[319-64*i -: 64];
    end

    assign w_base      = 6'(int'(r_cnt) * PAR);
    assign w_lastBatch = (r_cnt == CW'(NB - 1));

    // Each lane gathers one column (x0 is the MSB) from the current batch
    for (genvar k = 0; k < PAR; k++) begin : g_lanes
        assign w_colIdx[k]  = w_base + 6'(k);
        assign w_sboxIn[k]  = {w_x[0][w_colIdx[k]], w_x[1][w_colIdx[k]], w_x[2][w_colIdx[k]],
                               w_x[3][w_colIdx[k]], w_x[4][w_colIdx[k]]};
        assign w_sboxOut[k] = r_inv ? sboxInv(w_sboxIn[k]) : sboxFwd(w_sboxIn[k]);
    end

    always_comb begin
        w_xSub = w_x;
        for (int k = 0; k < PAR; k++) begin
            w_xSub[0][w_colIdx[k]] = w_sboxOut[k][4];
            w_xSub[1][w_colIdx[k]] = w_sboxOut[k][3];
            w_xSub[2][w_colIdx[k]] = w_sboxOut[k][2];
            w_xSub[3][w_colIdx[k]] = w_sboxOut[k][1];
            w_xSub[4][w_colIdx[k]] = w_sboxOut[k][0];
        end
    end

    assign w_stateSub = {w_xSub[0], w_xSub[1], w_xSub[2], w_xSub[3], w_xSub[4]};

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsmNext;
        end
    end

    always_comb begin
        w_fsmNext = r_fsm;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (start_i) begin
                    w_fsmNext = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (w_lastBatch) begin
                    w_fsmNext = DONE;
                end
            end
            DONE: begin
                busy_o    = 1'b1;
                done_o    = 1'b1;
                w_fsmNext = IDLE;
            end
            default: w_fsmNext = IDLE;
        endcase
    end

    // Inputs are captured only while idle; the register then substitutes in place
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (start_i) begin
                        r_state <= state_i;
                        r_inv   <= inv_i;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_state <= w_stateSub;
                    r_cnt   <= w_lastBatch ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_ascon_sbox_layer_seq.sv
// Scoreboard bench for ascon_sbox_layer_seq: table-driven column model, directed and
// random layers, held-start, and mid-run reset.
module tb_ascon_sbox_layer_seq;

    localparam int PAR     = 8;
    localparam int NB      = 64 / PAR;
    localparam int TIMEOUT = 200;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ZERO = 64'h0;

    logic         clock;
    logic         resetb;
    logic         start;
    logic         inv;
    logic [319:0] stateIn;
    logic [319:0] stateOut;
    logic         busy;
    logic         done;

    int checkCount = 0;
    int passCount  = 0;

    logic [319:0] sbQ[$];
    logic [319:0] expState;

    logic [4:0] fwdTab [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
    logic [4:0] invTab [32];

    ascon_sbox_layer_seq #(.PAR(PAR)) dut (
        .clock_i (clock),
        .resetb_i(resetb),
        .start_i (start),
        .inv_i   (inv),
        .state_i (stateIn),
        .state_o (stateOut),
        .busy_o  (busy),
        .done_o  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [319:0] refLayer(input logic [319:0] s, input logic mode);
        logic [63:0] a0, a1, a2, a3, a4;
        logic [5:0]  c;
        logic [4:0]  v;
        {a0, a1, a2, a3, a4} = s;
        for (int j = 0; j < 64; j++) begin
            c = j[5:0];
            v = {a0[c], a1[c], a2[c], a3[c], a4[c]};
            v = mode ? invTab[v] : fwdTab[v];
            {a0[c], a1[c], a2[c], a3[c], a4[c]} = v;
        end
        return {a0, a1, a2, a3, a4};
    endfunction

    function automatic logic [319:0] randState();
        logic [319:0] r;
        for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [319:0] got, input logic [319:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clock) begin
        if (resetb && done) begin
            if (sbQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL spurious done: got done=1 expected no pending layer");
            end else begin
                expState = sbQ.pop_front();
                checkOutput("layer result", stateOut, expState);
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (busy && n < TIMEOUT) begin
            @(negedge clock);
            n++;
        end
        checkOutput("wait idle", 320'(busy), 320'(0));
    endtask

    task automatic applyStimulus(input logic [319:0] s, input logic mode, input logic [319:0] exp);
        int lat;
        int busyCycles;
        waitIdle();
        @(negedge clock);
        start   = 1'b1;
        stateIn = s;
        inv     = mode;
        sbQ.push_back(exp);
        @(negedge clock);
        start   = 1'b0;
        stateIn = randState();
        inv     = 1'($urandom);
        lat        = 1;
        busyCycles = 0;
        while (!done && lat < TIMEOUT) begin
            if (busy) busyCycles++;
            @(negedge clock);
            lat++;
        end
        if (busy) busyCycles++;
        checkOutput("latency", 320'(lat), 320'(NB + 1));
        checkOutput("busy cycles", 320'(busyCycles), 320'(NB + 1));
        @(negedge clock);
        checkOutput("busy after done", 320'(busy), 320'(0));
    endtask

    task automatic holdStartTest();
        logic [319:0] a, b;
        int lat;
        waitIdle();
        a = randState();
        b = randState();
        @(negedge clock);
        start   = 1'b1;
        stateIn = a;
        inv     = 1'b0;
        sbQ.push_back(refLayer(a, 1'b0));
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (!done) begin
                stateIn = randState();
                inv     = 1'($urandom);
            end
        end while (!done && lat < TIMEOUT);
        checkOutput("held start latency", 320'(lat), 320'(NB + 1));
        stateIn = b;
        inv     = 1'b1;
        sbQ.push_back(refLayer(b, 1'b1));
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (lat >= 2 && !done) begin
                stateIn = randState();
                inv     = 1'($urandom);
            end
        end while (!done && lat < TIMEOUT);
        checkOutput("restart spacing", 320'(lat), 320'(NB + 2));
        start = 1'b0;
    endtask

    task automatic resetMidRun();
        logic [319:0] s;
        waitIdle();
        s = randState();
        @(negedge clock);
        start   = 1'b1;
        stateIn = s;
        inv     = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        resetb = 1'b0;
        #1;
        checkOutput("abort state", stateOut, 320'(0));
        checkOutput("abort busy", 320'(busy), 320'(0));
        checkOutput("abort done", 320'(done), 320'(0));
        @(posedge clock);
        #2;
        resetb = 1'b1;
        applyStimulus(s, 1'b0, refLayer(s, 1'b0));
    endtask

    initial begin
        logic [319:0] s, f;
        logic [4:0]   cv;
        for (int i = 0; i < 32; i++) invTab[fwdTab[i]] = 5'(i);

        resetb  = 1'b0;
        start   = 1'b0;
        inv     = 1'b0;
        stateIn = '1;
        repeat (2) @(negedge clock);
        checkOutput("reset state", stateOut, 320'(0));
        checkOutput("reset busy", 320'(busy), 320'(0));
        checkOutput("reset done", 320'(done), 320'(0));
        resetb = 1'b1;

        applyStimulus('0, 1'b0, {ZERO, ZERO, ONES, ZERO, ZERO});
        applyStimulus('0, 1'b1, {ONES, ZERO, ONES, ZERO, ZERO});
        applyStimulus({ONES, ZERO, ONES, ZERO, ZERO}, 1'b0, '0);
        applyStimulus('1, 1'b0, {ONES, ZERO, ONES, ONES, ONES});

        // Every value 0..31 lands in every column position, both modes
        for (int v = 0; v < 32; v++) begin
            s = '0;
            for (int j = 0; j < 64; j++) begin
                cv = 5'(v + j);
                s[256 + j] = cv[4];
                s[192 + j] = cv[3];
                s[128 + j] = cv[2];
                s[64 + j]  = cv[1];
                s[j]       = cv[0];
            end
            applyStimulus(s, 1'b0, refLayer(s, 1'b0));
            applyStimulus(s, 1'b1, refLayer(s, 1'b1));
        end

        for (int n = 0; n < 200; n++) begin
            s = randState();
            f = refLayer(s, 1'b0);
            applyStimulus(s, 1'b0, f);
            applyStimulus(f, 1'b1, s);
        end

        holdStartTest();
        resetMidRun();

        waitIdle();
        repeat (3) @(negedge clock);
        checkOutput("scoreboard drained", 320'(sbQ.size()), 320'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
